// File: rtl/rr_packet_arbiter.sv
// Per-output wormhole packet arbiter: round-robin over header requests, locked until the tail flit.
// Optional stall timeout is enabled with `define ARB_TIMEOUT_EN.
module rr_packet_arbiter #(
  parameter int unsigned NUM_IN    = 5,
  parameter int unsigned LEN_WIDTH = 12,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN-1:0]           req,
  input  logic [NUM_IN-1:0]           hdr,
  input  logic [NUM_IN*LEN_WIDTH-1:0] len,
  input  logic                        dcts,
  output logic [NUM_IN-1:0]           grant,
  output logic                        busy,
  output logic [2:0]                  owner,
  output logic                        err
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           owner_q, owner_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_arr [NUM_IN];
  logic [LEN_WIDTH-1:0] win_len;
  logic [NUM_IN-1:0]    cand;
  logic [2:0]           idx;
  logic [2:0]           win;
  logic                 found;
  logic                 granted;
  logic                 timeout_fire;

  assign cand = req & hdr;

  always_comb begin
    for (int i = 0; i < int'(NUM_IN); i++) begin
      len_arr[i] = len[i*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  // Scan downward so the last hit (closest to ptr) wins.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      idx = 3'((int'(ptr_q) + i) % int'(NUM_IN));
      if (cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign win_len = len_arr[win];
  assign granted = (state_q == StActive) && dcts && req[owner_q];

  always_comb begin
    grant = '0;
    if (granted) grant[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StActive;
          owner_d = win;
          cnt_d   = (win_len == '0) ? LEN_WIDTH'(1) : win_len;
          ptr_d   = (win == 3'(NUM_IN - 1)) ? 3'd0 : win + 3'd1;
        end
      end
      StActive: begin
        if (granted) begin
          if (cnt_q != '0) cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) state_d = StIdle;
        end
        if (timeout_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned StallW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [StallW-1:0] stall_q, stall_d;
  logic              err_q;

  // Counter is held at zero while idle, which covers the clear on entry to ACTIVE.
  always_comb begin
    stall_d      = stall_q;
    timeout_fire = 1'b0;
    if (state_q == StIdle || granted) begin
      stall_d = '0;
    end else if (stall_q == StallW'(TIMEOUT - 1)) begin
      stall_d      = '0;
      timeout_fire = 1'b1;
    end else begin
      stall_d = stall_q + StallW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= timeout_fire;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg   = ^TIMEOUT;
  assign timeout_fire = 1'b0;
  assign err          = 1'b0;
`endif

  assign busy  = (state_q == StActive);
  assign owner = owner_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter: a packet-level model predicts every grant,
// a monitor pops and compares whenever the DUT grants.
module tb_rr_packet_arbiter;

  localparam int N  = 5;
  localparam int LW = 12;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  hdr;
  logic [N*LW-1:0] len;
  logic          dcts;
  logic [N-1:0]  grant;
  logic          busy;
  logic [2:0]    owner;
  logic          err;

  rr_packet_arbiter #(
    .NUM_IN   (N),
    .LEN_WIDTH(LW),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .hdr  (hdr),
    .len  (len),
    .dcts (dcts),
    .grant(grant),
    .busy (busy),
    .owner(owner),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [4:0] g;
  } exp_t;
  exp_t sb[$];

  // Reference model: one packet in flight, counted in remaining flits.
  int m_active = 0;
  int m_owner  = 0;
  int m_left   = 0;
  int m_ptr    = 0;
  int m_stall  = 0;
  int m_err    = 0;
  int len_v[N];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_owner  = 0;
    m_left   = 0;
    m_ptr    = 0;
    m_stall  = 0;
    m_err    = 0;
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0] h, input logic d);
    logic [4:0] g;
    logic [4:0] c;
    int         nerr;
    int         j;
    int         l;
    @(negedge clk);
    rst  = 1'b0;
    req  = r;
    hdr  = h;
    dcts = d;
    for (int i = 0; i < N; i++) len[i*LW +: LW] = len_v[i][LW-1:0];
    #1;
    check("busy", int'(busy), m_active);
    check("owner", int'(owner), m_owner);
    check("err", int'(err), m_err);
    g = '0;
    if (m_active != 0 && d && r[m_owner]) g[m_owner] = 1'b1;
    if (g != 0) sb.push_back('{cyc, g});
    nerr = 0;
    if (m_active == 0) begin
      c = r & h;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (m_active == 0 && c[j]) begin
          l        = len_v[j] % (1 << LW);
          m_active = 1;
          m_owner  = j;
          m_left   = (l == 0) ? 1 : l;
          m_ptr    = (j + 1) % N;
          m_stall  = 0;
        end
      end
    end else if (g != 0) begin
      m_left  = m_left - 1;
      m_stall = 0;
      if (m_left == 0) m_active = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      m_stall = m_stall + 1;
      if (m_stall == TO) begin
        m_active = 0;
        m_stall  = 0;
        nerr     = 1;
      end
`endif
    end
    m_err = nerr;
  endtask

  // Asynchronous reset between edges; next step releases it.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_err", int'(err), 0);
    model_reset();
  endtask

  // Monitor: compare each DUT grant against the oldest predicted grant.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (grant !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_unexpected at cycle %0d: got %b expected none", cyc, grant);
      end else begin
        e = sb.pop_front();
        check("grant_cycle", cyc, e.cyc);
        check("grant_vec", int'(grant), int'(e.g));
      end
    end
  end

  initial begin
    logic [8:0] pat;
    rst  = 1'b0;
    req  = '0;
    hdr  = '0;
    dcts = 1'b0;
    len  = '0;
    for (int i = 0; i < N; i++) len_v[i] = 0;
    #1;
    rst = 1'b1;
    #1;
    check("reset_grant", int'(grant), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_owner", int'(owner), 0);
    check("reset_err", int'(err), 0);
    model_reset();

    // Single requester E, len 3.
    len_v[2] = 3;
    step(5'b00100, 5'b00100, 1'b1);
    repeat (3) step(5'b00100, 5'b00000, 1'b1);
    repeat (2) step(5'b00000, 5'b00000, 1'b1);

    // Round-robin with every input requesting, len 2 each.
    for (int i = 0; i < N; i++) len_v[i] = 2;
    repeat (18) step(5'b11111, 5'b11111, 1'b1);
    repeat (2) step(5'b00000, 5'b00000, 1'b1);

    // Backpressure on N, len 4.
    len_v[1] = 4;
    step(5'b00010, 5'b00010, 1'b1);
    pat = 9'b001110011;
    for (int i = 0; i < 9; i++) step(5'b00010, 5'b00000, pat[i]);

    // Zero length on W, then E len 6 with L and S contending.
    len_v[3] = 0;
    step(5'b01000, 5'b01000, 1'b1);
    repeat (2) step(5'b00000, 5'b00000, 1'b1);
    len_v[2] = 6;
    step(5'b00100, 5'b00100, 1'b1);
    repeat (9) step(5'b10101, 5'b10001, 1'b1);
    repeat (2) step(5'b00000, 5'b00000, 1'b1);

    // Reset in the middle of a 5-flit packet, then restart from L.
    len_v[1] = 5;
    step(5'b00010, 5'b00010, 1'b1);
    repeat (2) step(5'b00010, 5'b00000, 1'b1);
    async_reset();
    for (int i = 0; i < N; i++) len_v[i] = 1;
    repeat (6) step(5'b11111, 5'b11111, 1'b1);
    repeat (2) step(5'b00000, 5'b00000, 1'b1);

    // Owner L stalls with req low while E waits.
    len_v[0] = 3;
    step(5'b00001, 5'b00001, 1'b1);
    repeat (12) step(5'b00100, 5'b00100, 1'b1);
    repeat (4) step(5'b00101, 5'b00000, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) len_v[i] = $urandom_range(0, 6);
      step(5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
    end

    repeat (4) step(5'b00000, 5'b00000, 1'b1);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
